// File: rtl/axil_cfg_reg_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : axil_cfg_reg_slave_if
// Brief    : AXI4-Lite bus bundle (no wstrb) for the classification config slave.
// Revision : 1.0  initial release
// ============================================================================
interface axil_cfg_reg_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface
`default_nettype wire

// File: rtl/axil_cfg_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_cfg_reg_slave
// Brief    : AXI4-Lite register file staging classification-table entries and
//            committing one entry per START_ADDR write on a valid/ready port.
// Revision : 1.0  initial release
// ============================================================================
module axil_cfg_reg_slave #(
    parameter int AXIL_ADDR_WIDTH = 32,
    parameter int AXIL_DATA_WIDTH = 32
) (
    input  wire logic                 axil_clk,
    input  wire logic                 axil_rst,
    axil_cfg_reg_slave_if.slave       s_axil,
    output logic                      cfg_valid,
    input  wire logic                 cfg_ready,
    output logic [31:0]               cfg_sfa,
    output logic [7:0]                cfg_op,
    output logic [1:0]                cfg_pktid_ext,
    output logic [4:0]                cfg_idx_ext,
    output logic [31:0]               cfg_start_addr,
    output logic                      user_rst
);
    // Word addresses (addr[13:2])
    localparam logic [11:0] c_addr_user_reset = 12'h840;
    localparam logic [11:0] c_addr_sfa        = 12'h841;
    localparam logic [11:0] c_addr_op         = 12'h842;
    localparam logic [11:0] c_addr_start      = 12'h843;
    localparam logic [11:0] c_addr_count      = 12'h844;
    localparam logic [1:0]  c_resp_okay       = 2'b00;
    localparam logic [1:0]  c_resp_slverr     = 2'b10;

    typedef enum logic [2:0] {
        W_IDLE = 3'd0,
        W_DATA = 3'd1,
        W_ADDR = 3'd2,
        W_EXEC = 3'd3,
        W_RESP = 3'd4
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    w_state_t                   r_wstate;
    r_state_t                   r_rstate;
    logic [11:0]                r_waddr;
    logic [AXIL_DATA_WIDTH-1:0] r_wdata;
    logic [31:0]                r_sfa;
    logic [7:0]                 r_op;
    logic [1:0]                 r_pktid;
    logic [4:0]                 r_idx;
    logic [31:0]                r_start_addr;
    logic [31:0]                r_cfg_count;
    logic                       r_awready;
    logic                       r_wready;
    logic                       r_bvalid;
    logic [1:0]                 r_bresp;
    logic                       r_arready;
    logic                       r_rvalid;
    logic [31:0]                r_rdata;
    logic [1:0]                 r_rresp;
    logic                       r_cfg_valid;
    logic [31:0]                r_cfg_sfa;
    logic [7:0]                 r_cfg_op;
    logic [1:0]                 r_cfg_pktid;
    logic [4:0]                 r_cfg_idx;
    logic [31:0]                r_cfg_start;
    logic                       r_user_rst;

    logic        w_cfg_hs;
    logic        w_stall;
    logic [31:0] w_rd_data;
    logic        w_rd_err;
    logic        w_unused;

    assign w_cfg_hs = r_cfg_valid && cfg_ready;
    // A new commit must wait until the table has taken the pending entry.
    assign w_stall  = (r_waddr == c_addr_start) && r_cfg_valid && !cfg_ready;
    assign w_unused = ^{s_axil.awaddr[AXIL_ADDR_WIDTH-1:14], s_axil.awaddr[1:0],
                        s_axil.araddr[AXIL_ADDR_WIDTH-1:14], s_axil.araddr[1:0]};

    always_ff @(posedge axil_clk) begin
        if (axil_rst) begin
            r_wstate     <= W_IDLE;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_sfa        <= '0;
            r_op         <= '0;
            r_pktid      <= '0;
            r_idx        <= '0;
            r_start_addr <= '0;
            r_cfg_count  <= '0;
            r_awready    <= 1'b1;
            r_wready     <= 1'b1;
            r_bvalid     <= 1'b0;
            r_bresp      <= c_resp_okay;
            r_cfg_valid  <= 1'b0;
            r_cfg_sfa    <= '0;
            r_cfg_op     <= '0;
            r_cfg_pktid  <= '0;
            r_cfg_idx    <= '0;
            r_cfg_start  <= '0;
            r_user_rst   <= 1'b0;
        end else begin
            r_user_rst <= 1'b0;
            if (w_cfg_hs) begin
                r_cfg_valid <= 1'b0;
                r_cfg_count <= r_cfg_count + 32'd1;
            end
            case (r_wstate)
                W_IDLE: begin
                    if (s_axil.awvalid) r_waddr <= s_axil.awaddr[13:2];
                    if (s_axil.wvalid)  r_wdata <= s_axil.wdata;
                    if (s_axil.awvalid && s_axil.wvalid) begin
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_wstate  <= W_EXEC;
                    end else if (s_axil.awvalid) begin
                        r_awready <= 1'b0;
                        r_wstate  <= W_DATA;
                    end else if (s_axil.wvalid) begin
                        r_wready  <= 1'b0;
                        r_wstate  <= W_ADDR;
                    end
                end
                W_DATA: if (s_axil.wvalid) begin
                    r_wdata  <= s_axil.wdata;
                    r_wready <= 1'b0;
                    r_wstate <= W_EXEC;
                end
                W_ADDR: if (s_axil.awvalid) begin
                    r_waddr   <= s_axil.awaddr[13:2];
                    r_awready <= 1'b0;
                    r_wstate  <= W_EXEC;
                end
                W_EXEC: if (!w_stall) begin
                    r_bvalid <= 1'b1;
                    r_bresp  <= c_resp_okay;
                    r_wstate <= W_RESP;
                    case (r_waddr)
                        c_addr_user_reset: if (r_wdata[0]) begin
                            r_user_rst   <= 1'b1;
                            r_sfa        <= '0;
                            r_op         <= '0;
                            r_pktid      <= '0;
                            r_idx        <= '0;
                            r_start_addr <= '0;
                            r_cfg_count  <= '0;
                            r_cfg_valid  <= 1'b0;
                        end
                        c_addr_sfa: r_sfa <= r_wdata[31:0];
                        c_addr_op:  {r_op, r_pktid, r_idx} <= r_wdata[14:0];
                        c_addr_start: begin
                            // Snapshot overrides a same-cycle handshake clear.
                            r_start_addr <= r_wdata[31:0];
                            r_cfg_valid  <= 1'b1;
                            r_cfg_sfa    <= r_sfa;
                            r_cfg_op     <= r_op;
                            r_cfg_pktid  <= r_pktid;
                            r_cfg_idx    <= r_idx;
                            r_cfg_start  <= r_wdata[31:0];
                        end
                        default: r_bresp <= c_resp_slverr;
                    endcase
                end
                W_RESP: if (s_axil.bready) begin
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b1;
                    r_wready  <= 1'b1;
                    r_wstate  <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_err  = 1'b0;
        case (s_axil.araddr[13:2])
            c_addr_user_reset: w_rd_data = '0;
            c_addr_sfa:        w_rd_data = r_sfa;
            c_addr_op:         w_rd_data = {17'd0, r_op, r_pktid, r_idx};
            c_addr_start:      w_rd_data = r_start_addr;
            c_addr_count:      w_rd_data = r_cfg_count;
            default:           w_rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge axil_clk) begin
        if (axil_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
        end else begin
            case (r_rstate)
                R_IDLE: if (s_axil.arvalid) begin
                    r_arready <= 1'b0;
                    r_rvalid  <= 1'b1;
                    r_rdata   <= w_rd_data;
                    r_rresp   <= w_rd_err ? c_resp_slverr : c_resp_okay;
                    r_rstate  <= R_DATA;
                end
                R_DATA: if (s_axil.rready) begin
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b1;
                    r_rstate  <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axil.awready = r_awready;
    assign s_axil.wready  = r_wready;
    assign s_axil.bvalid  = r_bvalid;
    assign s_axil.bresp   = r_bresp;
    assign s_axil.arready = r_arready;
    assign s_axil.rvalid  = r_rvalid;
    assign s_axil.rdata   = r_rdata;
    assign s_axil.rresp   = r_rresp;

    assign cfg_valid      = r_cfg_valid;
    assign cfg_sfa        = r_cfg_sfa;
    assign cfg_op         = r_cfg_op;
    assign cfg_pktid_ext  = r_cfg_pktid;
    assign cfg_idx_ext    = r_cfg_idx;
    assign cfg_start_addr = r_cfg_start;
    assign user_rst       = r_user_rst;
endmodule
`default_nettype wire
